// File: rtl/seg_scan_ctrl_if.sv
// Load handshake between the display-value source and the scan controller.
// The source drives valid/value; the controller answers with ready.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load_valid;
    logic [4*DIGITS-1:0]   load_value;
    logic                  load_ready;

    modport master (output load_valid, output load_value, input load_ready);
    modport slave  (input load_valid, input load_value, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with frame-aligned value
// commit, hex decode, leading-zero blanking and per-slot ghost blanking.
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              lz_blank,
    seg_scan_ctrl_if.slave    load_if,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              frame_tick
);
    localparam int CW = $clog2(DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;

    logic [3:0]            nib [DIGITS];
    logic [DIGITS-1:0]     nib_zero;
    logic [DIGITS-1:0]     blank_vec;
    logic                  cnt_last, fb, accept, commit, lit;

    function automatic logic [6:0] hex_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    // A digit is blanked when it and every more-significant digit are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign nib[gi]      = disp_q[4*gi +: 4];
        assign nib_zero[gi] = (nib[gi] == 4'h0);
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = lz_blank & (&nib_zero[DIGITS-1:gi]);
        end
    end

    assign load_if.load_ready = ~pend_full_q;

    always_comb begin
        cnt_last = (cnt_q == CW'(DIV - 1));
        fb       = cnt_last && (idx_q == IW'(DIGITS - 1));
        accept   = load_if.load_valid && !pend_full_q;
        commit   = fb && pend_full_q;

        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_last) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end

        // accept and commit are mutually exclusive: accept needs pend empty.
        pend_d      = accept ? load_if.load_value : pend_q;
        pend_full_d = accept ? 1'b1 : (commit ? 1'b0 : pend_full_q);
        disp_d      = commit ? pend_q : disp_q;

        frame_tick_d = fb;

        lit   = enable && (cnt_q >= CW'(BLANK_CYC)) && !blank_vec[idx_q];
        an_d  = lit ? ~(DIGITS'(1) << idx_q) : '1;
        seg_d = lit ? ~hex_pattern(nib[idx_q]) : 7'h7F;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It sits between the counter/arithmetic datapath and the board display pins, sharing one segment bus among DIGITS anodes. It accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so the display never tears. It provides hex decoding, leading-zero blanking and inter-digit ghost blanking.

## Interface
- DIGITS, 4: number of digits / anodes; digit 0 is least significant.
- DIV, 50000: clk cycles per digit slot; DIV ≥ BLANK_CYC+2.
- BLANK_CYC, 2: cycles at the start of each slot with all anodes off.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-low.
- enable  input  1  0 forces display dark; scan counters keep running.
- lz_blank  input  1  1 suppresses leading zeros.
- load_valid  input  1  value is offered.
- load_value  input  4*DIGITS  hex nibbles; nibble i occupies bits 4i+3:4i.
- load_ready  output  1  controller can accept a value.
- an  output  DIGITS  active-low anode enables.
- seg  output  7  active-low segments; bit0=a … bit6=g.
- frame_tick  output  1  one-cycle pulse per completed frame.

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps. Slot index idx counts 0..DIGITS-1 and advances when cnt==DIV-1. It wraps to 0 after DIGITS-1.
- Frame boundary (FB) is the edge at which cnt==DIV-1 and idx==DIGITS-1.
- Registers:
  - disp: the value currently shown.
  - pend: the captured value waiting to be committed.
  - pend_full: flag marking pend as occupied.
- load_ready = ~pend_full.
- Accept happens at an edge where load_valid && load_ready. At that edge, pend <= load_value and pend_full <= 1.
- Commit happens at FB when pend_full==1. At that edge, disp <= pend and pend_full <= 0.
- Accept and FB on the same edge: pend_full was 0, so there is nothing to commit. The value is captured and commits at the next FB.
- load_valid while load_ready==0 is ignored. The source must hold valid until it is accepted.
- Decode: each nibble maps to an active-high pattern p, and seg = ~p. Patterns for 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Leading-zero blanking: digit i>0 is blanked when lz_blank==1 and all disp nibbles j≥i are 0. Digit 0 is never blanked.
- Drive for the current slot:
  - Dark (an all 1, seg 7F) if enable==0, or cnt<BLANK_CYC, or the digit is blanked.
  - Otherwise only an[idx]=0, and seg = ~p(disp nibble idx).

## Timing
- Reset values:
  - cnt=0, idx=0, disp=0, pend=0, pend_full=0.
  - load_ready=1, an=all 1, seg=7F, frame_tick=0.
- an and seg are registered. The levels in cycle t reflect cnt, idx, disp, enable and lz_blank sampled at the edge opening cycle t, i.e. one cycle of latency.
- frame_tick is registered: high for exactly the one cycle following each FB edge, independent of enable.
- A commit at an FB is visible on an/seg starting with slot 0 of the new frame, after that slot's BLANK_CYC dark cycles.
- load_ready goes low the cycle after an accept. It returns high the cycle after the committing FB.
- Frame period is DIGITS*DIV cycles. Each digit is lit for DIV-BLANK_CYC cycles per frame.
- Reset asserted mid-frame returns all state to reset values asynchronously. A pending value is discarded.
- After reset release, the first FB occurs DIGITS*DIV edges later.

## Test plan
Parameters for all scenarios: DIGITS=4, DIV=8, BLANK_CYC=2, enable=1 unless stated.

1. Reset, then present 0x1234 with valid for one cycle → load_ready low the next cycle. After the first FB:
   - slot 0 shows an=1110, seg=19 (the digit 4).
   - slot 3 shows an=0111, seg=79 (the digit 1).
   - Each slot has 2 dark cycles first. load_ready is high again the cycle after the FB.
2. Load 0x0050 with lz_blank=1 →
   - slots 3 and 2 are dark (an=1111, seg=7F).
   - slot 1 shows seg=12.
   - slot 0 shows seg=40.
   - With lz_blank=0, slots 3 and 2 show seg=40.
3. Offer 0xAAAA while pend_full=1, then hold 0xBEEF valid → 0xAAAA is ignored. 0xBEEF is accepted the cycle after the pending commit and displays one frame later; slot 0 shows seg=0E (the digit F).
4. Drop enable for 10 cycles mid-slot → an=1111 and seg=7F on the following cycles. frame_tick keeps pulsing every 32 cycles. The display resumes in the correct slot.
5. Assert reset while pend_full=1 and slot 2 is lit → an=1111, seg=7F and load_ready=1 immediately. disp is 0; a value shown after release is the reset value 0, not the pending one.
6. Run 3 frames → frame_tick is high exactly 1 cycle per 32. Digit order is 0,1,2,3. There are never two anode bits low at once.
